// File: rtl/alu_stage.sv
// Registered ARM data-processing ALU stage with a one-entry valid/ready output register.
// Owns the NZCV flag register; updated on S-bit accepts or by an explicit flag load.
module alu_stage #(
    parameter int unsigned WIDTH     = 32,
    parameter logic [3:0]  RST_FLAGS = 4'b0000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       opcode,
    input  logic             s_bit,
    input  logic [3:0]       rd_in,
    input  logic [WIDTH-1:0] rn,
    input  logic [WIDTH-1:0] shifter_operand,
    input  logic             shifter_cout,
    input  logic             flag_load,
    input  logic [3:0]       flag_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [3:0]       rd_out,
    output logic             write_en,
    output logic [3:0]       flags
);

    localparam int unsigned SIGN = WIDTH - 1;

    typedef enum logic [3:0] {
        OP_AND = 4'h0, OP_EOR = 4'h1, OP_SUB = 4'h2, OP_RSB = 4'h3,
        OP_ADD = 4'h4, OP_ADC = 4'h5, OP_SBC = 4'h6, OP_RSC = 4'h7,
        OP_TST = 4'h8, OP_TEQ = 4'h9, OP_CMP = 4'hA, OP_CMN = 4'hB,
        OP_ORR = 4'hC, OP_MOV = 4'hD, OP_BIC = 4'hE, OP_MVN = 4'hF
    } alu_op_e;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } ostate_e;

    typedef struct packed {
        logic n;
        logic z;
        logic c;
        logic v;
    } nzcv_t;

    alu_op_e          op;
    ostate_e          state;
    ostate_e          state_next;
    logic             capture;
    logic             carry_flag;
    logic             is_arith;
    logic             writes_rd;
    logic [WIDTH-1:0] add_a;
    logic [WIDTH-1:0] add_b;
    logic             add_cin;
    logic [WIDTH:0]   sum;
    logic             add_v;
    logic [WIDTH-1:0] alu_res;
    nzcv_t            next_nzcv;

    assign op         = alu_op_e'(opcode);
    assign carry_flag = flags[1];

    // Adder operand steering: subtracts become A + ~B + 1 (or + C for SBC/RSC).
    always_comb begin
        add_a    = rn;
        add_b    = shifter_operand;
        add_cin  = 1'b0;
        is_arith = 1'b0;
        case (op)
            OP_SUB, OP_CMP: begin
                add_b    = ~shifter_operand;
                add_cin  = 1'b1;
                is_arith = 1'b1;
            end
            OP_RSB: begin
                add_a    = shifter_operand;
                add_b    = ~rn;
                add_cin  = 1'b1;
                is_arith = 1'b1;
            end
            OP_ADD, OP_CMN: begin
                is_arith = 1'b1;
            end
            OP_ADC: begin
                add_cin  = carry_flag;
                is_arith = 1'b1;
            end
            OP_SBC: begin
                add_b    = ~shifter_operand;
                add_cin  = carry_flag;
                is_arith = 1'b1;
            end
            OP_RSC: begin
                add_a    = shifter_operand;
                add_b    = ~rn;
                add_cin  = carry_flag;
                is_arith = 1'b1;
            end
            default: ;
        endcase
    end

    assign sum   = {1'b0, add_a} + {1'b0, add_b} + (WIDTH+1)'(add_cin);
    assign add_v = (add_a[SIGN] == add_b[SIGN]) & (sum[SIGN] != add_a[SIGN]);

    // Result select; arithmetic ops take the adder sum.
    always_comb begin
        alu_res = sum[WIDTH-1:0];
        case (op)
            OP_AND, OP_TST: alu_res = rn & shifter_operand;
            OP_EOR, OP_TEQ: alu_res = rn ^ shifter_operand;
            OP_ORR:         alu_res = rn | shifter_operand;
            OP_MOV:         alu_res = shifter_operand;
            OP_BIC:         alu_res = rn & ~shifter_operand;
            OP_MVN:         alu_res = ~shifter_operand;
            default:        ;
        endcase
    end

    // Logical ops take C from the shifter and leave V alone.
    always_comb begin
        next_nzcv.n = alu_res[SIGN];
        next_nzcv.z = (alu_res == '0);
        next_nzcv.c = is_arith ? sum[WIDTH] : shifter_cout;
        next_nzcv.v = is_arith ? add_v : flags[0];
    end

    assign writes_rd = !(op inside {OP_TST, OP_TEQ, OP_CMP, OP_CMN});

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= EMPTY;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            EMPTY: if (capture) state_next = FULL;
            FULL:  if (out_ready && !capture) state_next = EMPTY;
            default: state_next = EMPTY;
        endcase
    end

    // Ready passes through when the held result drains this cycle.
    always_comb begin
        out_valid = (state == FULL);
        in_ready  = !out_valid || out_ready;
        capture   = in_valid && in_ready;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            result   <= '0;
            rd_out   <= '0;
            write_en <= 1'b0;
        end else if (capture) begin
            result   <= alu_res;
            rd_out   <= rd_in;
            write_en <= writes_rd;
        end
    end

    // An explicit flag load overrides a same-cycle S-bit update.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            flags <= RST_FLAGS;
        end else if (flag_load) begin
            flags <= flag_data;
        end else if (capture && s_bit) begin
            flags <= next_nzcv;
        end
    end

endmodule
